iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, handshaked successor to the core's single-cycle combinational ALU.
- Single-cycle ops give a registered result one cycle after acceptance.
- Adds iterative MUL (low word), DIVU and REMU that take WIDTH cycles.
- Sits between the decode/operand stage and writeback. Issue and completion use valid/ready handshakes, so the pipeline can stall on long ops.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two, at least 8.
- DIV_EN, 1, 1 enables DIVU/REMU; 0 makes those codes return 0 in one cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and ctrl are presented.
- in_ready  out  1  block can accept a new operation.
- ALUop1  in  WIDTH  operand 1.
- ALUop2  in  WIDTH  operand 2.
- ALUctrl  in  4  operation select.
- out_valid  out  1  Result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  WIDTH  operation result.
- EQ  out  1  ALUop1 == ALUop2, captured at acceptance; valid for every op.
- Zero  out  1  Result == 0.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE; Result=0; EQ=0; Zero=0; out_valid=0; busy=0; in_ready=1.
  - Iteration counter and all internal registers cleared.
  - Reset asserted mid-operation aborts it; no result is produced.
- ALUctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU; both give 1 or 0, zero-extended.
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL, 1011 DIVU, 1100 REMU.
  - 1101-1111 reserved: Result=0, single-cycle.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry output.
  - Shift amount is ALUop2[log2(WIDTH)-1:0]; upper bits are ignored.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0, busy=1.
  - DONE: in_ready=0, out_valid=1, Result/EQ/Zero held stable.
- Transitions:
  - IDLE, accept (in_valid & in_ready):
    - Single-cycle op or reserved code: result registered, go to DONE. out_valid rises the next cycle (latency 1).
    - MUL, or DIVU/REMU with DIV_EN=1: operands latched, counter=WIDTH, go to BUSY.
    - DIVU/REMU with DIV_EN=0: handled as single-cycle, Result=0.
  - BUSY: one iteration per cycle, counter decrements. When counter reaches 0, go to DONE. out_valid rises exactly WIDTH+1 cycles after acceptance.
  - DONE & out_ready: go to IDLE. The next op can be accepted in the cycle after the handshake (no overlap).
- Iterative algorithms:
  - MUL: shift-add over unsigned operands; low WIDTH bits returned, which equals the signed low word.
  - DIVU/REMU: restoring division, one quotient bit per cycle.
  - Divide by zero: DIVU returns all-ones; REMU returns ALUop1. Same WIDTH-cycle latency, no trap.
- Operand capture:
  - EQ is computed from the operands at acceptance.
  - Changes on ALUop1/ALUop2/ALUctrl after acceptance have no effect.
- Output stability: Zero is derived from the registered Result. Result, EQ and Zero change only on entry to DONE, or on reset.
- Handshake rules:
  - in_valid with in_ready=0 is ignored; the source must hold its request.
  - out_valid stays high until out_ready is seen, with no limit on backpressure.
  - Zero-wait case: out_ready held high gives a single-cycle DONE.

Test Plan:
- Reset with in_valid=1 asserted -> all outputs 0 and in_ready=1 while rst_n=0; no accept occurs until rst_n rises.
- ADD 0xFFFFFFFF+1 (WIDTH=32) -> Result=0, Zero=1, EQ=0, out_valid one cycle after accept. SUB 5-5 -> Result=0, EQ=1. SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0. SRA 0x80000000 by 0x24 (amount 4) -> 0xF8000000.
- MUL 0x0001_0003 x 0x0000_0005 -> Result=0x0005_000F with out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 throughout; a second in_valid during BUSY is not accepted.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each with 33-cycle latency.
- Backpressure: out_ready held low 10 cycles after DONE -> Result stable, out_valid=1, in_ready=0; releasing out_ready -> IDLE next cycle and a back-to-back ADD is accepted.
- Deassert rst_n mid-MUL (cycle 12) -> immediate IDLE, out_valid never asserted for that op; a subsequent XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0. Repeat one DIVU with DIV_EN=0 -> Result=0, latency 1.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with single-cycle ops and
// iterative MUL / DIVU / REMU taking WIDTH cycles.
module iter_alu #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] ALUop2,
  input  logic [3:0]       ALUctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             EQ,
  output logic             Zero,
  output logic             busy
);

  localparam int SH = $clog2(WIDTH);
  localparam int CW = SH + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             is_div;
  logic             want_rem;
  logic             eq_cap;

  logic [SH-1:0]    shamt;
  logic [WIDTH-1:0] quick;
  logic             is_iter;
  logic             is_dv;

  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] step_res;

  assign shamt = ALUop2[SH-1:0];
  assign is_dv = (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
  assign is_iter = (ALUctrl == OP_MUL) || (DIV_EN && is_dv);

  // DIVU/REMU with DIV_EN=0 and reserved codes fall to default 0
  always_comb begin
    quick = '0;
    case (ALUctrl)
      OP_ADD:  quick = ALUop1 + ALUop2;
      OP_SUB:  quick = ALUop1 - ALUop2;
      OP_AND:  quick = ALUop1 & ALUop2;
      OP_OR:   quick = ALUop1 | ALUop2;
      OP_XOR:  quick = ALUop1 ^ ALUop2;
      OP_SLT:  quick = WIDTH'($signed(ALUop1) < $signed(ALUop2));
      OP_SLTU: quick = WIDTH'(ALUop1 < ALUop2);
      OP_SLL:  quick = ALUop1 << shamt;
      OP_SRL:  quick = ALUop1 >> shamt;
      OP_SRA:  quick = $unsigned($signed(ALUop1) >>> shamt);
      default: quick = '0;
    endcase
  end

  // acc doubles as product accumulator and partial remainder;
  // opa holds multiplicand or the dividend shifting into quotient
  always_comb begin
    mul_acc_n = opb[0] ? (acc + opa) : acc;
    r_sh      = {acc, opa[WIDTH-1]};
    diff      = r_sh - {1'b0, opb};
    ge        = ~diff[WIDTH];
    rem_n     = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    quo_n     = {opa[WIDTH-2:0], ge};
    step_res  = mul_acc_n;
    if (is_div) begin
      step_res = want_rem ? rem_n : quo_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      want_rem  <= 1'b0;
      eq_cap    <= 1'b0;
      Result    <= '0;
      EQ        <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_iter) begin
              acc      <= '0;
              opa      <= ALUop1;
              opb      <= ALUop2;
              is_div   <= (ALUctrl != OP_MUL);
              want_rem <= (ALUctrl == OP_REMU);
              eq_cap   <= (ALUop1 == ALUop2);
              cnt      <= CW'(WIDTH);
              busy     <= 1'b1;
              state    <= BUSY;
            end else begin
              Result    <= quick;
              Zero      <= (quick == '0);
              EQ        <= (ALUop1 == ALUop2);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            acc <= rem_n;
            opa <= quo_n;
          end else begin
            acc <= mul_acc_n;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
          if (cnt == CW'(1)) begin
            Result    <= step_res;
            Zero      <= (step_res == '0);
            EQ        <= eq_cap;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: table, hand-written and random checks
// of iter_alu against an arithmetic reference model.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic [3:0]  ALUctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        EQ;
  logic        Zero;
  logic        busy;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] result2;
  logic        eq2;
  logic        zero2;
  logic        busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .EQ(EQ), .Zero(Zero), .busy(busy)
  );

  iter_alu #(.WIDTH(32), .DIV_EN(1'b0)) dut_nodiv (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .Result(result2), .EQ(eq2), .Zero(zero2), .busy(busy2)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          bp;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [63:0] p;
    logic [31:0] r;
    sh = b % 32;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = a << sh;
      4'd8:  r = a >> sh;
      4'd9:  r = $signed(a) >>> sh;
      4'd10: r = p[31:0];
      4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_long(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
  endfunction

  // called at posedge+1; returns at posedge+1 back in IDLE
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int bp, input string name);
    int n;
    int lat;
    bit ok;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk({name, "_idle_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    ALUctrl = op;
    ALUop1 = a;
    ALUop2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALUop1 = $urandom;
    ALUop2 = $urandom;
    ALUctrl = 4'($urandom_range(0, 15));
    lat = 1;
    ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (is_long(op)) chk({name, "_busyflags"}, 32'(ok), 32'd1);
    chk({name, "_latency"}, lat, is_long(op) ? 32'd33 : 32'd1);
    if (!out_valid) return;
    chk({name, "_result"}, Result, exp);
    chk({name, "_zero"}, 32'(Zero), 32'(exp == 0));
    chk({name, "_eq"}, 32'(EQ), 32'(a == b));
    ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || Result !== exp) ok = 1'b0;
    end
    if (bp > 0) chk({name, "_hold"}, 32'(ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    bit ok;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vt[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h1, 32'h0, 0};
    vt[1]  = '{4'd1,  32'h5, 32'h5, 32'h0, 0};
    vt[2]  = '{4'd5,  32'hFFFF_FFFF, 32'h1, 32'h1, 0};
    vt[3]  = '{4'd6,  32'hFFFF_FFFF, 32'h1, 32'h0, 0};
    vt[4]  = '{4'd9,  32'h8000_0000, 32'h24, 32'hF800_0000, 0};
    vt[5]  = '{4'd10, 32'h0001_0003, 32'h5, 32'h0005_000F, 0};
    vt[6]  = '{4'd11, 32'd100, 32'd7, 32'd14, 0};
    vt[7]  = '{4'd12, 32'd100, 32'd7, 32'd2, 0};
    vt[8]  = '{4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 0};
    vt[9]  = '{4'd12, 32'd9, 32'd0, 32'd9, 0};
    vt[10] = '{4'd2,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 0};
    vt[11] = '{4'd3,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_F0F0, 1};
    vt[12] = '{4'd7,  32'h1, 32'h3F, 32'h8000_0000, 0};
    vt[13] = '{4'd8,  32'h8000_0000, 32'h21, 32'h4000_0000, 0};
    vt[14] = '{4'd13, 32'h1234, 32'h5678, 32'h0, 2};
    vt[15] = '{4'd0,  32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 10};
    vt[16] = '{4'd0,  32'h1, 32'h2, 32'h3, 0};
    vt[17] = '{4'd1,  32'h0, 32'h1, 32'hFFFF_FFFF, 3};

    // reset held with a request pending
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_valid2 = 1'b0;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
    ALUctrl = 4'd0;
    ALUop1 = 32'h7;
    ALUop2 = 32'h7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'h0);
    chk("rst_flags", {27'd0, EQ, Zero, out_valid, busy, in_ready},
        32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_noaccept", {30'd0, out_valid, in_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].bp,
             $sformatf("vec%0d", i));
    end

    // request held during BUSY must be ignored
    ALUctrl = 4'd10;
    ALUop1 = 32'h0001_0003;
    ALUop2 = 32'h5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    ALUctrl = 4'd0;
    ALUop1 = 32'h1;
    ALUop2 = 32'h1;
    lat = 1;
    ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (lat == 10) in_valid = 1'b0;
      if (!busy || in_ready) ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    chk("busy_ignore_flags", 32'(ok), 32'd1);
    chk("busy_ignore_lat", lat, 32'd33);
    chk("busy_ignore_res", Result, 32'h0005_000F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) ok = 1'b0;
    end
    chk("busy_ignore_none", 32'(ok), 32'd1);

    // reset in the middle of a multiply
    ALUctrl = 4'd10;
    ALUop1 = 32'hDEAD_BEEF;
    ALUop2 = 32'h1234_5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk("abort_result", Result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ok = 1'b0;
    end
    chk("abort_no_result", 32'(ok), 32'd1);
    run_op(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0,
           "xor_after_abort");

    // DIVU on a build without the divider
    ALUctrl = 4'd11;
    ALUop1 = 32'd100;
    ALUop2 = 32'd7;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("nodiv_lat1", {30'd0, out_valid2, busy2}, 32'd2);
    chk("nodiv_result", result2, 32'h0);
    chk("nodiv_zero", 32'(zero2), 32'd1);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    chk("nodiv_release", {30'd0, out_valid2, in_ready2}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      run_op(op, a, b, model(op, a, b), $urandom_range(0, 3),
             $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
